// File: rtl/des_pkg.sv
//------------------------------------------------------------------------------
// Module  : des_pkg
// Brief   : Shared widths, state encoding, shift schedule and rotate helpers
//           for the iterative DES round controller.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package des_pkg;

  localparam int HALF_W = 32;
  localparam int CD_W   = 56;
  localparam int KH_W   = CD_W / 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ROUND = ST_ROUND,
    DONE  = ST_DONE
  } state_t;

  // Per-round left-shift amounts of the key schedule, rounds 1..16.
  localparam logic [1:0] DES_SHIFT [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [KH_W-1:0] rotl_half(input logic [KH_W-1:0] x,
                                                input logic [1:0]      n);
    case (n)
      2'd1:    rotl_half = {x[KH_W-2:0], x[KH_W-1]};
      2'd2:    rotl_half = {x[KH_W-3:0], x[KH_W-1:KH_W-2]};
      default: rotl_half = x;
    endcase
  endfunction

  function automatic logic [KH_W-1:0] rotr_half(input logic [KH_W-1:0] x,
                                                input logic [1:0]      n);
    case (n)
      2'd1:    rotr_half = {x[0], x[KH_W-1:1]};
      2'd2:    rotr_half = {x[1:0], x[KH_W-1:2]};
      default: rotr_half = x;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_key_rotator.sv
//------------------------------------------------------------------------------
// Module  : des_key_rotator
// Brief   : Combinational per-round C/D rotation; left for encrypt, right
//           (reverse schedule) for decrypt, so no subkeys need storing.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module des_key_rotator
  import des_pkg::*;
(
  input  logic [CD_W-1:0] i_cd,
  input  logic [3:0]      i_round,
  input  logic            i_decrypt,
  output logic [CD_W-1:0] o_cd_rot
);

  logic [4:0] w_round_num;
  logic [4:0] w_tab_idx;
  logic [1:0] w_amt;

  assign w_round_num = {1'b0, i_round} + 5'd1;

  // Decrypt walks the schedule backwards; its first round needs no rotation.
  always_comb begin
    w_tab_idx = i_decrypt ? (5'd18 - w_round_num) : w_round_num;
    w_amt     = 2'd0;
    if (!i_decrypt || (w_round_num >= 5'd2)) begin
      for (int k = 1; k <= 16; k++) begin
        if (w_tab_idx == k[4:0]) w_amt = DES_SHIFT[k];
      end
    end
  end

  assign o_cd_rot = i_decrypt
                  ? {rotr_half(i_cd[CD_W-1:KH_W], w_amt), rotr_half(i_cd[KH_W-1:0], w_amt)}
                  : {rotl_half(i_cd[CD_W-1:KH_W], w_amt), rotl_half(i_cd[KH_W-1:0], w_amt)};

endmodule

`default_nettype wire

// File: rtl/des_round_ctrl.sv
//------------------------------------------------------------------------------
// Module  : des_round_ctrl
// Brief   : Iterative DES round sequencer: one Feistel round per clock with an
//           external round function, valid/ready on input and output.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_decrypt,
  input  logic [63:0]       in_block,
  input  logic [CD_W-1:0]   in_key_cd,
  input  logic              flush,
  output logic [HALF_W-1:0] round_r,
  output logic [CD_W-1:0]   round_cd,
  output logic [3:0]        round_idx,
  input  logic [HALF_W-1:0] f_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_block,
  output logic              busy
);

  localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cnt;
  logic [HALF_W-1:0] r_l;
  logic [HALF_W-1:0] r_r;
  logic [CD_W-1:0]   r_cd;
  logic              r_dec;
  logic [CD_W-1:0]   w_round_cd;

  des_key_rotator u_rot (
    .i_cd      (r_cd),
    .i_round   (r_cnt),
    .i_decrypt (r_dec),
    .o_cd_rot  (w_round_cd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_l     <= '0;
      r_r     <= '0;
      r_cd    <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (flush) begin
        r_cnt <= '0;
      end else if (r_state == IDLE && in_valid) begin
        r_l   <= in_block[63:32];
        r_r   <= in_block[31:0];
        r_cd  <= in_key_cd;
        r_dec <= in_decrypt;
        r_cnt <= '0;
      end else if (r_state == ROUND) begin
        r_l   <= r_r;
        r_r   <= r_l ^ f_result;
        r_cd  <= w_round_cd;
        // Hold at the last round so the 4-bit counter never wraps.
        r_cnt <= (r_cnt == c_last_round) ? r_cnt : r_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    out_block    = '0;
    round_idx    = '0;
    round_r      = '0;
    round_cd     = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next_state = ROUND;
      end
      ROUND: begin
        round_idx = r_cnt;
        round_r   = r_r;
        round_cd  = w_round_cd;
        if (r_cnt == c_last_round) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = {r_r, r_l};
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

endmodule

`default_nettype wire

// File: tb/tb_des_round_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_des_round_ctrl
// Brief   : Directed bench for des_round_ctrl with a PC-2/f model and a
//           subkey-table DES reference.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_des_round_ctrl;

  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                                26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                                51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_decrypt, flush;
  logic [63:0] in_block, out_block;
  logic [55:0] in_key_cd, round_cd;
  logic [31:0] round_r, f_result;
  logic [3:0]  round_idx;
  logic        out_valid, out_ready, busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [55:0] cd_r0, cd_r1;

  always #5 clk = ~clk;

  des_round_ctrl #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_decrypt(in_decrypt), .in_block(in_block), .in_key_cd(in_key_cd),
    .flush(flush), .round_r(round_r), .round_cd(round_cd), .round_idx(round_idx),
    .f_result(f_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy)
  );

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [55:0] cd);
    logic [47:0] k, e, x;
    logic [31:0] s, p;
    logic [5:0]  six;
    int          idx;
    for (int i = 0; i < 48; i++) begin
      k[47-i] = cd[56-PC2_T[i]];
      e[47-i] = r[32-E_T[i]];
    end
    x = e ^ k;
    for (int j = 0; j < 8; j++) begin
      six = x[47-6*j -: 6];
      idx = {26'd0, six[5], six[0], six[4:1]};
      s[31-4*j -: 4] = SB[j][255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rl28(input logic [27:0] x, input int n);
    return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  // Reference: precomputed subkey table, used in reverse order for decrypt.
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [55:0] cd,
                                          input logic dec);
    logic [55:0] ks [16];
    logic [55:0] c;
    logic [31:0] l, r, t;
    c = cd;
    for (int i = 0; i < 16; i++) begin
      c = {rl28(c[55:28], SH_T[i]), rl28(c[27:0], SH_T[i])};
      ks[i] = c;
    end
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_model(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return {r, l};
  endfunction

  assign f_result = f_model(round_r, round_cd);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [63:0] blk, input logic [55:0] cd, input logic dec);
    in_block   = blk;
    in_key_cd  = cd;
    in_decrypt = dec;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_block   = ~blk;
    in_key_cd  = ~cd;
    in_decrypt = ~dec;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (busy && round_idx == 4'd0) cd_r0 = round_cd;
      if (busy && round_idx == 4'd1) cd_r1 = round_cd;
      step();
      lat++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk({tag, "_blk"}, out_block, 64'd0);
    chk({tag, "_rnd"}, {round_idx, round_r}, 64'd0);
    chk({tag, "_cd"}, round_cd, 64'd0);
  endtask

  localparam logic [63:0] BLK0 = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [55:0] CD0  = 56'hF0CCAAF_556678F;
  localparam logic [63:0] PRE  = 64'h0A4CD995_43423234;

  initial begin
    int          lat, n, seen, cyc, na, nr;
    int          acc [3];
    logic        acc_now;
    logic [63:0] jb [3];
    logic [55:0] jk [3];
    logic        jd [3];
    logic [63:0] jr [3];
    logic [63:0] xb;
    logic [55:0] xk;

    rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_block = '0;
    in_key_cd = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk_reset("por");
    rst_n = 1'b1;
    step();

    // Known vector, encrypt
    start_job(BLK0, CD0, 1'b0);
    wait_done(lat);
    chk("enc_latency", lat, 17);
    chk("enc_r0_cd", cd_r0, 56'hE19955F_AACCF1E);
    chk("enc_block", out_block, PRE);
    chk("enc_cipher", fp(out_block), 64'h85E813540F0AB405);
    step();
    chk("enc_release", {61'd0, in_ready, out_valid, busy}, 64'd4);

    // Decrypt round trip
    start_job(PRE, CD0, 1'b1);
    wait_done(lat);
    chk("dec_latency", lat, 17);
    chk("dec_r0_cd", cd_r0, CD0);
    chk("dec_r1_cd", cd_r1, 56'hF866557_AAB33C7);
    chk("dec_block", out_block, BLK0);
    chk("dec_plain", fp(out_block), 64'h0123456789ABCDEF);
    step();

    // Backpressure
    out_ready = 1'b0;
    start_job(BLK0, CD0, 1'b0);
    wait_done(lat);
    for (int k = 0; k < 10; k++) begin
      chk("bp_ctl", {62'd0, out_valid, in_ready}, 64'd2);
      chk("bp_block", out_block, PRE);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", {61'd0, in_ready, out_valid, busy}, 64'd4);

    // Flush at round 7, then flush with in_valid in IDLE
    start_job(BLK0, CD0, 1'b0);
    n = 0;
    while (round_idx != 4'd7 && n < 40) begin step(); n++; end
    chk("fl_reach7", {60'd0, round_idx}, 64'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_idle", {61'd0, in_ready, out_valid, busy}, 64'd4);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) seen++;
      step();
    end
    chk("fl_no_out", seen, 0);
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("fl_no_accept", {63'd0, busy}, 64'd0);
    xb = 64'h1F2E3D4C5B6A7988;
    xk = 56'h0123456789ABCD;
    start_job(xb, xk, 1'b0);
    wait_done(lat);
    chk("fl_next_job", out_block, des_ref(xb, xk, 1'b0));
    step();

    // Reset mid-job and reset with in_valid
    start_job(BLK0, CD0, 1'b1);
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    step();
    chk_reset("rst_mid");
    in_valid = 1'b1;
    step();
    chk_reset("rst_valid");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("rst_no_job", {63'd0, busy}, 64'd0);

    // Back-to-back with in_valid held high
    for (int k = 0; k < 3; k++) begin
      jb[k] = {$urandom(), $urandom()};
      jk[k] = 56'({$urandom(), $urandom()});
      jd[k] = 1'($urandom_range(0, 1));
      jr[k] = des_ref(jb[k], jk[k], jd[k]);
    end
    na = 0; nr = 0; cyc = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    in_block = jb[0]; in_key_cd = jk[0]; in_decrypt = jd[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (nr < 3 && cyc < 100) begin
      acc_now = 1'b0;
      if (out_valid) begin
        chk($sformatf("b2b_result%0d", nr), out_block, jr[nr]);
        nr++;
      end
      if (in_ready && in_valid) begin
        acc[na] = cyc;
        na++;
        acc_now = 1'b1;
      end
      step();
      cyc++;
      if (acc_now) begin
        if (na < 3) begin
          in_block = jb[na]; in_key_cd = jk[na]; in_decrypt = jd[na];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", nr, 3);
    chk("b2b_gap01", acc[1] - acc[0], 18);
    chk("b2b_gap12", acc[2] - acc[1], 18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
